// File: rtl/fma_exp_pipe.sv
// Pipelined FMA product-exponent / addend-alignment unit with a valid/ready
// handshake, collapsing bubbles and a synchronous flush.
module fma_exp_pipe #(
  parameter int unsigned NE      = 11,
  parameter int unsigned NF      = 52,
  parameter int unsigned STAGES  = 2,
  parameter logic [3:0]  FMTMASK = 4'b0011
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          Flush,
  input  logic          InValid,
  output logic          InReady,
  input  logic [1:0]    Fmt,
  input  logic [NE-1:0] Xe,
  input  logic [NE-1:0] Ye,
  input  logic [NE-1:0] Ze,
  input  logic          XZero,
  input  logic          YZero,
  input  logic          ZZero,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [NE+1:0] Pe,
  output logic [NE+1:0] ACnt,
  output logic          KillProd,
  output logic          KillZ,
  output logic          FmtErr
);

  localparam int unsigned W = NE + 2;

  typedef struct packed {
    logic [W-1:0] pe;
    logic [W-1:0] acnt;
    logic         kill_prod;
    logic         kill_z;
    logic         fmt_err;
  } res_t;

  if (FMTMASK[3] && (NE < 15)) begin : g_cfg_q_bias
    $error("fma_exp_pipe: quad format enabled but NE=%0d is below 15", NE);
  end
  if ((STAGES < 1) || (STAGES > 4)) begin : g_cfg_stages
    $error("fma_exp_pipe: STAGES=%0d outside 1..4", STAGES);
  end

  logic [W-1:0] bias;
  logic [W-1:0] pe_c;
  logic [W-1:0] acnt_c;
  logic         pzero;
  res_t         stage_in;

  always_comb begin
    bias = '0;
    if (FMTMASK[Fmt]) begin
      case (Fmt)
        2'd0:    bias = W'(127);
        2'd1:    bias = W'(1023);
        2'd2:    bias = W'(15);
        default: bias = W'(16383);
      endcase
    end
    pzero  = XZero | YZero;
    pe_c   = pzero ? '0 : (W'(Xe) + W'(Ye) - bias);
    acnt_c = pe_c - W'(Ze) + W'(NF + 2);

    stage_in.pe        = pe_c;
    stage_in.acnt      = acnt_c;
    stage_in.kill_prod = pzero | (acnt_c[W-1] & ~ZZero);
    stage_in.kill_z    = ZZero | (~acnt_c[W-1] & (acnt_c > W'(3 * NF + 3)));
    stage_in.fmt_err   = ~FMTMASK[Fmt];
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] load;
  res_t              data_q [STAGES];
  res_t              src    [STAGES];

  // A slot can take new data when it, or any slot downstream of it, is empty,
  // or when the output is being drained; this collapses bubbles under stall.
  always_comb begin : p_ctrl
    logic        full;
    int unsigned j;
    full    = 1'b1;
    j       = 0;
    en      = '0;
    src_v   = '0;
    load    = '0;
    valid_d = valid_q;
    for (int unsigned i = 0; i < STAGES; i++) begin
      j     = STAGES - 1 - i;
      full  = full & valid_q[j];
      en[j] = ~full | OutReady;
    end
    src[0]   = stage_in;
    src_v[0] = InValid;
    for (int unsigned i = 1; i < STAGES; i++) begin
      src[i]   = data_q[i-1];
      src_v[i] = valid_q[i-1];
    end
    for (int unsigned i = 0; i < STAGES; i++) begin
      load[i] = en[i] & src_v[i];
      if (en[i]) begin
        valid_d[i] = src_v[i];
      end
    end
    if (Flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          data_q[i] <= src[i];
        end
      end
    end
  end

  assign InReady  = en[0];
  assign OutValid = valid_q[STAGES-1];

  // Stale slot contents are masked so nothing leaks out while OutValid is low.
  always_comb begin
    Pe       = '0;
    ACnt     = '0;
    KillProd = 1'b0;
    KillZ    = 1'b0;
    FmtErr   = 1'b0;
    if (valid_q[STAGES-1]) begin
      Pe       = data_q[STAGES-1].pe;
      ACnt     = data_q[STAGES-1].acnt;
      KillProd = data_q[STAGES-1].kill_prod;
      KillZ    = data_q[STAGES-1].kill_z;
      FmtErr   = data_q[STAGES-1].fmt_err;
    end
  end

endmodule

// File: tb/tb_fma_exp_pipe.sv
// Scoreboard bench for fma_exp_pipe: driver pushes reference results on
// accept, monitor compares whatever the pipeline presents.
module tb_fma_exp_pipe;

  localparam int unsigned NE      = 11;
  localparam int unsigned NF      = 52;
  localparam int unsigned STAGES  = 2;
  localparam logic [3:0]  FMTMASK = 4'b0011;

  typedef struct packed {
    logic [12:0] pe;
    logic [12:0] acnt;
    logic        kp;
    logic        kz;
    logic        fe;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          Flush;
  logic          InValid;
  logic          InReady;
  logic [1:0]    Fmt;
  logic [NE-1:0] Xe, Ye, Ze;
  logic          XZero, YZero, ZZero;
  logic          OutValid;
  logic          OutReady;
  logic [NE+1:0] Pe, ACnt;
  logic          KillProd, KillZ, FmtErr;

  int checks   = 0;
  int failures = 0;

  exp_t sbq[$];

  fma_exp_pipe #(.NE(NE), .NF(NF), .STAGES(STAGES), .FMTMASK(FMTMASK)) dut (
    .clk(clk), .reset_n(reset_n), .Flush(Flush), .InValid(InValid),
    .InReady(InReady), .Fmt(Fmt), .Xe(Xe), .Ye(Ye), .Ze(Ze),
    .XZero(XZero), .YZero(YZero), .ZZero(ZZero), .OutValid(OutValid),
    .OutReady(OutReady), .Pe(Pe), .ACnt(ACnt), .KillProd(KillProd),
    .KillZ(KillZ), .FmtErr(FmtErr)
  );

  always #5 clk = ~clk;

  // Reference: signed integer arithmetic, then wrap to 13 bits.
  function automatic exp_t model(input int fmt, input int xe, input int ye,
                                 input int ze, input bit xz, input bit yz,
                                 input bit zz);
    exp_t r;
    int   bias, pe, ac;
    bit   neg;
    case (fmt)
      0:       bias = 127;
      1:       bias = 1023;
      default: bias = 0;
    endcase
    pe     = (xz || yz) ? 0 : xe + ye - bias;
    ac     = pe - ze + int'(NF) + 2;
    r.pe   = pe[12:0];
    r.acnt = ac[12:0];
    neg    = (int'(r.acnt) >= 4096);
    r.kp   = xz || yz || (neg && !zz);
    r.kz   = zz || (!neg && int'(r.acnt) > 3 * int'(NF) + 3);
    r.fe   = (fmt > 1);
    return r;
  endfunction

  // Tracker: capture handshake away from the edge, apply at the edge.
  bit   cap_acc = 1'b0;
  bit   cap_fl  = 1'b0;
  exp_t cap_e;

  always @(negedge clk) begin
    cap_acc = reset_n && InValid && InReady;
    cap_fl  = Flush;
    cap_e   = model(int'(Fmt), int'(Xe), int'(Ye), int'(Ze), XZero, YZero, ZZero);
  end

  always @(posedge clk) begin
    if (!reset_n) sbq.delete();
    else if (cap_fl) sbq.delete();
    else if (cap_acc) sbq.push_back(cap_e);
  end

  always @(negedge reset_n) begin
    sbq.delete();
    cap_acc = 1'b0;
  end

  // Monitor
  always @(negedge clk) begin
    exp_t got;
    if (reset_n) begin
      got = {Pe, ACnt, KillProd, KillZ, FmtErr};
      checks++;
      if (OutValid) begin
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL spurious_out got pe=%h acnt=%h exp no output", Pe, ACnt);
        end else begin
          if (got !== sbq[0]) begin
            failures++;
            $display("FAIL out_data got pe=%h acnt=%h kp=%b kz=%b fe=%b exp pe=%h acnt=%h kp=%b kz=%b fe=%b",
                     got.pe, got.acnt, got.kp, got.kz, got.fe,
                     sbq[0].pe, sbq[0].acnt, sbq[0].kp, sbq[0].kz, sbq[0].fe);
          end
          if (OutReady) void'(sbq.pop_front());
        end
      end else if (got !== '0) begin
        failures++;
        $display("FAIL idle_gating got %h exp 0", got);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic set_op(input int f, input int xe, input int ye, input int ze,
                        input bit xz, input bit yz, input bit zz);
    Fmt = f[1:0]; Xe = xe[NE-1:0]; Ye = ye[NE-1:0]; Ze = ze[NE-1:0];
    XZero = xz; YZero = yz; ZZero = zz;
  endtask

  task automatic issue(input int f, input int xe, input int ye, input int ze,
                       input bit xz, input bit yz, input bit zz);
    bit ok;
    set_op(f, xe, ye, ze, xz, yz, zz);
    InValid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk); ok = InReady;
      @(posedge clk); #1;
    end
    InValid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout got InReady=0 exp 1");
    end
  endtask

  task automatic rand_op();
    int f, m;
    f = int'($urandom_range(0, 3));
    case (f)
      0: m = 255;
      2: m = 31;
      default: m = 2047;
    endcase
    set_op(f, int'($urandom) & m, int'($urandom) & m, int'($urandom) & m,
           ($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0);
  endtask

  // Issue one op into an empty pipe and time its arrival.
  task automatic lat_check(input string name);
    int cyc;
    bit seen;
    OutReady = 1'b1;
    issue(1, 1023, 1023, 1023, 0, 0, 0);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 10) begin
      cyc++;
      @(negedge clk); seen = OutValid;
    end
    chk(name, 64'(cyc), 64'(STAGES));
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    InValid = 1'b0; OutReady = 1'b1; Flush = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 64'(sbq.size()), 64'd0);
  endtask

  task automatic rand_phase(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      rand_op();
      InValid  = ($urandom % 4) != 0;
      OutReady = ($urandom % 3) != 0;
      Flush    = ($urandom % 32) == 0;
      @(posedge clk); #1;
    end
    Flush = 1'b0; InValid = 1'b0;
  endtask

  task automatic check_zero_outs(input string name);
    chk(name, {OutValid, Pe, ACnt, KillProd, KillZ, FmtErr}, '0);
    chk({name, "_inready"}, 64'(InReady), 64'd1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    set_op(0, 0, 0, 0, 0, 0, 0);
    #23 check_zero_outs("reset_state");
    #4 reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    lat_check("latency_d");
    issue(1, 1, 1, 2046, 0, 0, 0);
    issue(1, 1, 1, 2046, 0, 0, 1);
    issue(0, 127, 130, 100, 0, 0, 0);
    issue(0, 127, 130, 100, 1, 0, 0);
    issue(3, 5, 6, 3, 0, 0, 0);
    issue(2, 20, 20, 1, 0, 0, 0);
    issue(1, 2047, 2047, 0, 0, 0, 0);
    issue(1, 1100, 1100, 900, 0, 0, 0);
    wait_drain("drain_directed");

    // Back-to-back then stall
    for (int k = 0; k < 8; k++) begin
      rand_op();
      issue(int'(Fmt), int'(Xe), int'(Ye), int'(Ze), XZero, YZero, ZZero);
    end
    wait_drain("drain_b2b");
    OutReady = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      rand_op();
      InValid = 1'b1;
      @(negedge clk); if (InReady) n++;
      @(posedge clk); #1;
    end
    InValid = 1'b0;
    chk("stall_buffered", 64'(n), 64'(STAGES));
    wait_drain("drain_stall");

    // Flush: two ops held under stall plus a presented input
    OutReady = 1'b0;
    issue(0, 140, 140, 10, 0, 0, 0);
    issue(1, 1500, 900, 30, 0, 0, 0);
    rand_op();
    InValid = 1'b1; Flush = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
    @(negedge clk); chk("flush_outvalid", 64'(OutValid), 64'd0);
    @(posedge clk); #1;
    // Flush with one op in flight and an input accepted that cycle
    issue(0, 130, 130, 5, 0, 0, 0);
    rand_op();
    InValid = 1'b1; Flush = 1'b1;
    @(negedge clk); chk("flush_accept_ready", 64'(InReady), 64'd1);
    @(posedge clk); #1;
    InValid = 1'b0; Flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("flush2_outvalid", 64'(OutValid), 64'd0);
    end
    @(posedge clk); #1;
    lat_check("latency_after_flush");

    // Random traffic with an asynchronous reset in the middle
    rand_phase(200);
    @(posedge clk); #3;
    reset_n = 1'b0; InValid = 1'b0; Flush = 1'b0;
    #1 check_zero_outs("async_reset");
    #12 reset_n = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("post_reset_outvalid", 64'(OutValid), 64'd0);
    end
    @(posedge clk); #1;
    lat_check("latency_after_reset");
    rand_phase(200);
    wait_drain("drain_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fma_exp_pipe.md
Name: fma_exp_pipe

Overview:
- Pipelined, multi-format successor to the combinational FMA product-exponent adder.
- Computes, per operation:
  - product exponent Pe = Xe + Ye − bias(Fmt);
  - addend alignment count ACnt = Pe − Ze + NF + 2;
  - kill flags KillProd and KillZ.
- Parameterised pipeline depth, with a valid/ready handshake and a synchronous flush.
- Sits between the FPU unpack stage and the FMA alignment/multiplier datapath.

Parameters:
- NE, 11, exponent width of the widest supported format (8/11/15).
- NF, 52, fraction width of the widest format; used in ACnt and KillZ.
- STAGES, 2, number of register stages (1..4); latency in cycles.
- FMTMASK, 4'b0011, supported formats, indexed by Fmt:
  - bit0 S, bias 127;
  - bit1 D, bias 1023;
  - bit2 H, bias 15;
  - bit3 Q, bias 16383.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- Flush  in  1  synchronous kill of all in-flight operations
- InValid  in  1  input operation valid
- InReady  out  1  pipeline can accept this cycle
- Fmt  in  2  format: 00 S, 01 D, 10 H, 11 Q
- Xe, Ye, Ze  in  NE  biased exponents, native to Fmt, right-aligned, upper bits zero
- XZero, YZero, ZZero  in  1  operand is zero
- OutValid  out  1  result valid
- OutReady  in  1  consumer accepts result
- Pe  out  NE+2  product exponent, two's complement, in Fmt bias
- ACnt  out  NE+2  alignment shift count, two's complement
- KillProd  out  1  product negligible or zero
- KillZ  out  1  addend negligible or zero
- FmtErr  out  1  Fmt not enabled in FMTMASK

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset values: all stage valids 0; OutValid 0; Pe, ACnt 0; KillProd, KillZ, FmtErr 0. InReady is combinational and equals 1 immediately after reset.
- Arithmetic (stage 1, all NE+2 bits wide, inputs zero-extended):
  - Pe = PZero ? 0 : Xe + Ye − BIAS[Fmt], where PZero = XZero | YZero.
  - ACnt = Pe − Ze + (NF+2). Wraps modulo 2^(NE+2); no saturation.
  - KillProd = PZero | (ACnt[NE+1] & ~ZZero).
  - KillZ = ZZero | (~ACnt[NE+1] & ACnt > 3·NF+3), with the comparison unsigned.
  - NF is the widest format's value for all formats; narrower formats upstream pre-shift their fractions to NF.
- Format errors:
  - Fmt with FMTMASK bit clear: FmtErr = 1, bias treated as 0, operation otherwise flows normally.
  - The Q bias is only legal when NE ≥ 15; FMTMASK[3] with NE < 15 is a configuration error (elaboration assertion).
- Pipeline:
  - STAGES register slots, each with a valid bit. Stage 1 holds the computed results; later stages copy them.
  - Latency is STAGES cycles from InValid&InReady to OutValid when unstalled.
  - Throughput is 1 op/cycle.
- Handshake and stall:
  - Stage k advances when stage k+1 is empty or advancing.
  - The last stage advances when OutReady is high.
  - InReady = ~valid[1] | advance[1].
  - Bubbles collapse: an empty middle stage is filled even while the output is stalled.
- Output stability: while OutValid & ~OutReady, all outputs hold constant.
- Data gating: data registers load only on advance. Data in invalid slots is don't-care, but must not reach outputs while OutValid = 0.
- Flush:
  - Clears all valid bits at the next edge. InReady still reflects pre-flush state that cycle.
  - An input accepted in the flush cycle is discarded.
  - Flush has priority over advance.
- Reset mid-operation: all in-flight ops are lost; no output appears after reset release until a new op has traversed STAGES cycles.
- Simultaneous accept and drain at full occupancy with OutReady = 1: throughput stays 1/cycle with no bubble.
- STAGES = 1: InReady = ~OutValid | OutReady.

Test Plan:
- D format, Xe=1023, Ye=1023, Ze=1023, no zeros, STAGES=2 -> after 2 cycles Pe=1023, ACnt=54, KillProd=0, KillZ=0.
- D format, Xe=1, Ye=1, Ze=2046 -> Pe=−1021 (13'h1C03); ACnt negative, so KillProd=1, KillZ=0. Repeat with ZZero=1 -> KillProd=0, KillZ=1.
- S format, Xe=127, Ye=130 -> Pe=130. Same op with XZero=1 -> Pe=0, KillProd=1. Fmt=2'b11 with default FMTMASK -> FmtErr=1.
- Back-to-back 8 ops with OutReady=1 -> 8 results in order on consecutive cycles. Then hold OutReady=0 for 5 cycles -> InReady drops after STAGES ops are buffered, outputs stay stable, no loss or duplication on release.
- Flush asserted with 2 ops in flight plus an accepting input -> no OutValid for any of the 3; the next op emerges after STAGES cycles.
- reset_n pulsed low mid-stream, asynchronously and not clock-aligned -> OutValid=0 and all outputs 0 immediately; clean restart afterwards.
